matrix_loader: RTL and testbench

MATRIX_LOADER -- requirements
Module: matrix_loader

---
 rtl/jacobi_pkg.sv | 7 +
 rtl/matrix_addr_counter.sv | 27 ++
 rtl/matrix_loader.sv | 96 +++++++++
 tb/tb_matrix_loader.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/jacobi_pkg.sv
// jacobi_pkg: shared size defaults and loader state encoding
package jacobi_pkg;
  localparam int DEF_ADDR_WIDTH = 7;
  localparam int DEF_DATA_WIDTH = 20;
  localparam int DEF_MATRIX_N   = 8;
  typedef enum logic [1:0] {IDLE, LOAD, HANDOFF, WAIT_CORE} ld_state_t;
endpackage

// File: rtl/matrix_addr_counter.sv
// matrix_addr_counter: element counter with frame-end and s_last mismatch detection
module matrix_addr_counter
  import jacobi_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MATRIX_N   = DEF_MATRIX_N
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_inc,
  input  logic                  i_last,
  output logic [ADDR_WIDTH-1:0] o_cnt,
  output logic                  o_end,
  output logic                  o_err
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MATRIX_N * MATRIX_N - 1);
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  w_max;
  assign w_max = r_cnt == LAST;
  assign o_end = i_inc & (w_max | i_last);
  assign o_err = o_end & ~(w_max & i_last);
  assign o_cnt = r_cnt;
  // Count accepted beats; any frame end, clean or not, restarts the next frame at 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_inc) r_cnt <= o_end ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/matrix_loader.sv
// matrix_loader: streams a row-major matrix into RAM port A and hands the RAM to the Jacobi core
module matrix_loader
  import jacobi_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MATRIX_N   = DEF_MATRIX_N
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_en_b,
  output logic                  if_select,
  output logic                  core_start,
  input  logic                  core_done,
  output logic                  frame_err,
  output logic [7:0]            frames_loaded
);
  ld_state_t             r_state;
  logic                  r_s_ready, r_mem_en, r_mem_we, r_if_select, r_core_start, r_frame_err;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_din;
  logic [7:0]            r_frames_loaded;
  logic                  w_accept, w_end, w_err;
  logic [ADDR_WIDTH-1:0] w_cnt;
  assign w_accept      = s_valid & r_s_ready;
  assign s_ready       = r_s_ready;
  assign mem_en        = r_mem_en;
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_din       = r_mem_din;
  assign mem_en_b      = 1'b0;
  assign if_select     = r_if_select;
  assign core_start    = r_core_start;
  assign frame_err     = r_frame_err;
  assign frames_loaded = r_frames_loaded;
  matrix_addr_counter #(.ADDR_WIDTH(ADDR_WIDTH), .MATRIX_N(MATRIX_N)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_inc  (w_accept),
    .i_last (s_last),
    .o_cnt  (w_cnt),
    .o_end  (w_end),
    .o_err  (w_err)
  );
  // Loader FSM; the last write lands in HANDOFF so port A is idle before ownership flips
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state         <= IDLE;
      r_s_ready       <= 1'b0;
      r_mem_en        <= 1'b0;
      r_mem_we        <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_din       <= '0;
      r_if_select     <= 1'b0;
      r_core_start    <= 1'b0;
      r_frame_err     <= 1'b0;
      r_frames_loaded <= '0;
    end else begin
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_core_start <= 1'b0;
      case (r_state)
        IDLE, LOAD:
          if (w_accept) begin
            r_mem_en    <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= w_cnt;
            r_mem_din   <= s_data;
            r_state     <= !w_end ? LOAD : w_err ? IDLE : HANDOFF;
            r_s_ready   <= !w_end || w_err;
            r_frame_err <= r_frame_err | w_err;
          end else r_s_ready <= 1'b1;
        HANDOFF: begin
          r_state         <= WAIT_CORE;
          r_if_select     <= 1'b1;
          r_core_start    <= 1'b1;
          r_frames_loaded <= r_frames_loaded + 8'd1;
        end
        WAIT_CORE:
          if (core_done) begin
            r_state     <= IDLE;
            r_if_select <= 1'b0;
            r_s_ready   <= 1'b1;
          end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader: randomized scoreboard bench for matrix_loader
module tb_matrix_loader;
  localparam int AW = 7, DW = 20, N = 8, NN = N * N;
  logic          clk = 0, rst_n = 0, s_valid = 0, s_last = 0, core_done = 0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, mem_en, mem_we, mem_en_b, if_select, core_start, frame_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [7:0]    frames_loaded;
  typedef struct {int addr; int data; int cyc;} wr_t;
  typedef struct {int cyc; int fl;} st_t;
  wr_t wq[$];
  st_t sq[$];
  int checks = 0, errors = 0, cyc = 0, idx = 0, fl_exp = 0, starts = 0, s0;
  bit err_exp = 0;

  matrix_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MATRIX_N(N)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_en_b(mem_en_b), .if_select(if_select), .core_start(core_start), .core_done(core_done),
    .frame_err(frame_err), .frames_loaded(frames_loaded)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", n, act, exp);
    end
  endtask

  // Reference: frame position is the index within the frame; a frame closes on element NN-1 or s_last
  task automatic model(input logic [DW-1:0] d, input bit l);
    int acc = cyc + 1;
    wq.push_back('{idx, int'(d), acc});
    if (idx == NN - 1 || l) begin
      if (idx == NN - 1 && l) begin
        fl_exp = (fl_exp + 1) % 256;
        sq.push_back('{acc + 1, fl_exp});
      end else err_exp = 1;
      idx = 0;
    end else idx++;
  endtask

  task automatic beat(input logic [DW-1:0] d, input bit l, input int gap);
    int t = 0;
    while ($urandom_range(99) < gap) begin s_valid = 0; @(negedge clk); end
    s_valid = 1; s_data = d; s_last = l;
    while (!s_ready && t < 100) begin @(negedge clk); t++; end
    if (!s_ready) begin chk("beat_timeout", 1, 0); s_valid = 0; s_last = 0; return; end
    model(d, l);
    @(negedge clk);
    s_valid = 0; s_last = 0;
  endtask

  task automatic frame(input int n, input int last_at, input int gap, input bit seq);
    for (int i = 0; i < n; i++) beat(seq ? DW'(i) : DW'($urandom), i == last_at, gap);
  endtask

  task automatic core_ack(input int hold);
    int t = 0;
    while (!if_select && t < 20) begin @(negedge clk); t++; end
    chk("owner_core", if_select, 1);
    s_valid = hold > 0; s_data = DW'($urandom);
    for (int i = 0; i < hold; i++) begin
      chk("hold_ready", s_ready, 0);
      chk("hold_mem_en", mem_en, 0);
      @(negedge clk);
    end
    s_valid = 0; core_done = 1;
    @(negedge clk);
    core_done = 0;
    chk("rel_owner", if_select, 0);
    chk("rel_ready", s_ready, 1);
  endtask

  // Monitor: every write and every core_start must match the oldest expected event
  always @(negedge clk) begin
    wr_t w;
    st_t s;
    if (mem_en) begin
      if (wq.size() == 0) chk("spurious_write", 1, 0);
      else begin
        w = wq.pop_front();
        chk("wr_addr", mem_addr, w.addr);
        chk("wr_data", mem_din, w.data);
        chk("wr_cyc", cyc, w.cyc);
        chk("wr_we", mem_we, 1);
        chk("wr_owner", if_select, 0);
      end
    end
    if (core_start) begin
      starts++;
      if (sq.size() == 0) chk("spurious_start", 1, 0);
      else begin
        s = sq.pop_front();
        chk("start_cyc", cyc, s.cyc);
        chk("start_frames", frames_loaded, s.fl);
        chk("start_owner", if_select, 1);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_ready", s_ready, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_owner", if_select, 0);
    chk("rst_frames", frames_loaded, 0);
    chk("port_b_en", mem_en_b, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    chk("ready_after_rel0", s_ready, 0);
    @(negedge clk);
    chk("ready_after_rel1", s_ready, 1);
    frame(NN, NN - 1, 0, 1);
    core_ack(0);
    chk("frames_first", frames_loaded, 1);
    frame(NN, NN - 1, 50, 1);
    core_ack(20);
    core_done = 1; @(negedge clk); core_done = 0; @(negedge clk);
    chk("idle_done_owner", if_select, 0);
    chk("idle_done_ready", s_ready, 1);
    frame(11, 10, 0, 0);
    @(negedge clk); @(negedge clk);
    chk("early_err", frame_err, 1);
    chk("early_owner", if_select, 0);
    chk("early_ready", s_ready, 1);
    frame(NN, NN - 1, 20, 0);
    core_ack(0);
    chk("err_sticky", frame_err, 1);
    frame(NN, -1, 10, 0);
    @(negedge clk); @(negedge clk);
    chk("miss_err", frame_err, 1);
    chk("miss_owner", if_select, 0);
    chk("miss_ready", s_ready, 1);
    frame(30, -1, 0, 0);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("mid_rst_ready", s_ready, 0);
    chk("mid_rst_mem_en", mem_en, 0);
    chk("mid_rst_mem_we", mem_we, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_din", mem_din, 0);
    chk("mid_rst_owner", if_select, 0);
    chk("mid_rst_start", core_start, 0);
    chk("mid_rst_err", frame_err, 0);
    chk("mid_rst_frames", frames_loaded, 0);
    chk("mid_rst_pending", wq.size(), 0);
    wq.delete(); sq.delete();
    idx = 0; fl_exp = 0; err_exp = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    frame(NN, NN - 1, 0, 0);
    core_ack(0);
    chk("post_rst_err", frame_err, 0);
    s0 = starts;
    for (int f = 0; f < 255; f++) begin
      frame(NN, NN - 1, $urandom_range(20), 0);
      core_ack(0);
    end
    chk("frames_wrap", frames_loaded, 0);
    chk("frames_model", frames_loaded, fl_exp);
    chk("start_count", starts - s0, 255);
    chk("err_model", frame_err, err_exp);
    repeat (4) @(negedge clk);
    chk("wq_drained", wq.size(), 0);
    chk("sq_drained", sq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
